// File: rtl/lt24_pkg.sv
// Shared types and constants for the LT24 stream writer.
//   parser_state_e : byte-stream packet parser states
//   wr_state_e     : 8080-style write strobe engine states
//   lcd_word_t     : one queued LCD bus word {rs, data}
package lt24_pkg;

  localparam int FIFO_W     = 17;
  localparam int FIFO_DEPTH = 4;

  localparam logic [1:0] HDR_CMD  = 2'b10;
  localparam logic [1:0] HDR_DATA = 2'b01;

  typedef enum logic [1:0] {
    P_HDR,
    P_CMD,
    P_MSB,
    P_LSB
  } parser_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SETUP,
    W_LOW,
    W_HIGH
  } wr_state_e;

  typedef struct packed {
    logic        rs;
    logic [15:0] data;
  } lcd_word_t;

endpackage

// File: rtl/lt24_word_fifo.sv
// 4-deep synchronous FIFO of LCD words.
//   clk, reset    : clock, asynchronous active-low reset
//   push, wdata   : write request; accepted when not full, or when full and
//                   a pop happens in the same cycle
//   pop, rdata    : read request; rdata shows the head entry (show-ahead)
//   full, empty   : occupancy flags, decoded from the registered count
module lt24_word_fifo
  import lt24_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  lcd_word_t wdata,
  input  logic      pop,
  output lcd_word_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  lcd_word_t       mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, and a reset on the array would only cost area.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lt24_stream_writer.sv
// Parses framed command/pixel packets from the SPI byte stream, queues the
// resulting 16-bit words and plays them onto the LT24 8080-style write bus.
//   clk, reset              : clock, asynchronous active-low reset
//   data_in, data_in_enable : received byte and its one-cycle strobe
//   sync_clear              : returns the parser to header state
//   clr_status              : clears the sticky overflow / hdr_err flags
//   lt24_cs_n/rs/wr_n/rd_n/data : LCD bus
//   busy, overflow, hdr_err : status
module lt24_stream_writer
  import lt24_pkg::*;
#(
  parameter int WR_SETUP_CYC = 1,
  parameter int WR_LOW_CYC   = 2,
  parameter int WR_HIGH_CYC  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        data_in_enable,
  input  logic        sync_clear,
  input  logic        clr_status,
  output logic        lt24_cs_n,
  output logic        lt24_rs,
  output logic        lt24_wr_n,
  output logic        lt24_rd_n,
  output logic [15:0] lt24_data,
  output logic        busy,
  output logic        overflow,
  output logic        hdr_err
);

  localparam logic [7:0] SETUP_LAST = 8'(WR_SETUP_CYC - 1);
  localparam logic [7:0] LOW_LAST   = 8'(WR_LOW_CYC - 1);
  localparam logic [7:0] HIGH_LAST  = 8'(WR_HIGH_CYC - 1);

  // Parser
  parser_state_e p_state_q, p_state_d;
  logic [5:0]    words_left_q, words_left_d;
  logic [7:0]    msb_q, msb_d;
  logic          push;
  lcd_word_t     push_word;
  logic          hdr_err_set;

  // Write engine
  wr_state_e     w_state_q, w_state_d;
  logic [7:0]    cyc_q, cyc_d;
  logic          pop;
  lcd_word_t     head_word;
  logic          fifo_full;
  logic          fifo_empty;
  logic          overflow_set;

  assign lt24_rd_n = 1'b1;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    p_state_d    = p_state_q;
    words_left_d = words_left_q;
    msb_d        = msb_q;
    push         = 1'b0;
    push_word    = '0;
    hdr_err_set  = 1'b0;
    if (sync_clear) begin
      // Wins over a simultaneous byte; a half-received word is lost.
      p_state_d    = P_HDR;
      words_left_d = '0;
    end else if (data_in_enable) begin
      case (p_state_q)
        P_HDR: begin
          if (data_in[7:6] == HDR_CMD) begin
            p_state_d = P_CMD;
          end else if (data_in[7:6] == HDR_DATA) begin
            p_state_d    = P_MSB;
            words_left_d = data_in[5:0];
          end else begin
            hdr_err_set = 1'b1;
          end
        end
        P_CMD: begin
          push      = 1'b1;
          push_word = '{rs: 1'b0, data: {8'h00, data_in}};
          p_state_d = P_HDR;
        end
        P_MSB: begin
          msb_d     = data_in;
          p_state_d = P_LSB;
        end
        default: begin // P_LSB
          push      = 1'b1;
          push_word = '{rs: 1'b1, data: {msb_q, data_in}};
          if (words_left_q == '0) begin
            p_state_d = P_HDR;
          end else begin
            words_left_d = words_left_q - 1'b1;
            p_state_d    = P_MSB;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    cyc_d     = cyc_q + 8'd1;
    pop       = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        cyc_d = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          w_state_d = W_SETUP;
        end
      end
      W_SETUP: begin
        if (cyc_q == SETUP_LAST) begin
          w_state_d = W_LOW;
          cyc_d     = '0;
        end
      end
      W_LOW: begin
        if (cyc_q == LOW_LAST) begin
          w_state_d = W_HIGH;
          cyc_d     = '0;
        end
      end
      default: begin // W_HIGH
        if (cyc_q == HIGH_LAST) begin
          cyc_d = '0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            w_state_d = W_SETUP;
          end else begin
            w_state_d = W_IDLE;
          end
        end
      end
    endcase
  end

  assign overflow_set = push && fifo_full && !pop;

  lt24_word_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_state_q    <= P_HDR;
      words_left_q <= '0;
      msb_q        <= '0;
      w_state_q    <= W_IDLE;
      cyc_q        <= '0;
      lt24_cs_n    <= 1'b1;
      lt24_wr_n    <= 1'b1;
      lt24_rs      <= 1'b0;
      lt24_data    <= '0;
      overflow     <= 1'b0;
      hdr_err      <= 1'b0;
    end else begin
      p_state_q    <= p_state_d;
      words_left_q <= words_left_d;
      msb_q        <= msb_d;
      w_state_q    <= w_state_d;
      cyc_q        <= cyc_d;
      // Strobes are registered from the next state so they line up with it.
      lt24_cs_n    <= (w_state_d == W_IDLE);
      lt24_wr_n    <= (w_state_d != W_LOW);
      if (pop) begin
        lt24_rs   <= head_word.rs;
        lt24_data <= head_word.data;
      end
      if (overflow_set)    overflow <= 1'b1;
      else if (clr_status) overflow <= 1'b0;
      if (hdr_err_set)     hdr_err  <= 1'b1;
      else if (clr_status) hdr_err  <= 1'b0;
    end
  end

  // Decoded only from flops, so it drops to 0 the moment reset asserts.
  assign busy = (p_state_q != P_HDR) || !fifo_empty || (w_state_q != W_IDLE);

endmodule

// File: tb/tb_lt24_stream_writer.sv
// Directed self-checking bench for lt24_stream_writer (default timing 1/2/2).
module tb_lt24_stream_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data_in = '0;
  logic        data_in_enable = 1'b0;
  logic        sync_clear = 1'b0;
  logic        clr_status = 1'b0;
  logic        lt24_cs_n;
  logic        lt24_rs;
  logic        lt24_wr_n;
  logic        lt24_rd_n;
  logic [15:0] lt24_data;
  logic        busy;
  logic        overflow;
  logic        hdr_err;

  int checks = 0;
  int errors = 0;

  // Monitor: every rising edge of wr_n outside reset is one LCD write.
  logic [16:0] wlog [256];
  int          wr_total = 0;
  int          cs_low   = 0;
  int          wr_low   = 0;
  int          cs_rise  = 0;

  logic [7:0]  tx_q [$];

  lt24_stream_writer dut (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .data_in_enable (data_in_enable),
    .sync_clear     (sync_clear),
    .clr_status     (clr_status),
    .lt24_cs_n      (lt24_cs_n),
    .lt24_rs        (lt24_rs),
    .lt24_wr_n      (lt24_wr_n),
    .lt24_rd_n      (lt24_rd_n),
    .lt24_data      (lt24_data),
    .busy           (busy),
    .overflow       (overflow),
    .hdr_err        (hdr_err)
  );

  always #5 clk = ~clk;

  always @(posedge lt24_wr_n) begin
    if (reset === 1'b1) begin
      wlog[wr_total[7:0]] = {lt24_rs, lt24_data};
      wr_total++;
    end
  end

  always @(posedge lt24_cs_n) begin
    if (reset === 1'b1) cs_rise++;
  end

  always @(negedge clk) begin
    if (lt24_cs_n === 1'b0) cs_low++;
    if (lt24_wr_n === 1'b0) wr_low++;
  end

  // Strobes tx_q one byte per cycle; returns on the falling edge after the
  // rising edge that captured the final byte.
  task automatic send_q();
    for (int i = 0; i < tx_q.size(); i++) begin
      @(negedge clk);
      data_in        = tx_q[i];
      data_in_enable = 1'b1;
    end
    @(negedge clk);
    data_in_enable = 1'b0;
    data_in        = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({lt24_cs_n, lt24_wr_n, lt24_rd_n, lt24_rs, lt24_data, busy, overflow, hdr_err}
        !== {1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_in: cs_n=%b wr_n=%b rd_n=%b rs=%b data=%h busy=%b ovf=%b hdr=%b, expected 1 1 1 0 0000 0 0 0",
               lt24_cs_n, lt24_wr_n, lt24_rd_n, lt24_rs, lt24_data, busy, overflow, hdr_err);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({lt24_cs_n, lt24_wr_n, lt24_rd_n, busy} !== 4'b1110) begin
      errors++;
      $display("FAIL reset_out: cs_n/wr_n/rd_n/busy=%b, expected 1110",
               {lt24_cs_n, lt24_wr_n, lt24_rd_n, busy});
    end
  endtask

  task automatic test_command();
    int w0 = wr_total;
    int c0 = cs_low;
    int l0 = wr_low;
    tx_q = '{8'h80, 8'h2C};
    send_q();
    checks++;
    if ({lt24_cs_n, busy} !== 2'b11) begin
      errors++;
      $display("FAIL cmd_lat0: cs_n=%b busy=%b, expected 1 1", lt24_cs_n, busy);
    end
    @(negedge clk);
    checks++;
    if ({lt24_cs_n, lt24_wr_n, lt24_rs, lt24_data} !== {1'b0, 1'b1, 1'b0, 16'h002C}) begin
      errors++;
      $display("FAIL cmd_setup: cs_n=%b wr_n=%b rs=%b data=%h, expected 0 1 0 002c",
               lt24_cs_n, lt24_wr_n, lt24_rs, lt24_data);
    end
    @(negedge clk);
    checks++;
    if (lt24_wr_n !== 1'b0) begin
      errors++;
      $display("FAIL cmd_wr_fall: wr_n=%b, expected 0", lt24_wr_n);
    end
    wait_idle();
    checks++;
    if (wr_total - w0 != 1 || wlog[w0[7:0]] !== {1'b0, 16'h002C}) begin
      errors++;
      $display("FAIL cmd_write: count=%0d word=%h, expected 1 0002c", wr_total - w0, wlog[w0[7:0]]);
    end
    checks++;
    if (cs_low - c0 != 5 || wr_low - l0 != 2) begin
      errors++;
      $display("FAIL cmd_timing: cs_low=%0d wr_low=%0d, expected 5 2", cs_low - c0, wr_low - l0);
    end
    checks++;
    if (lt24_cs_n !== 1'b1) begin
      errors++;
      $display("FAIL cmd_cs_end: cs_n=%b, expected 1", lt24_cs_n);
    end
  endtask

  task automatic test_back_to_back();
    int w0 = wr_total;
    int c0 = cs_low;
    int r0 = cs_rise;
    tx_q = '{8'h41, 8'hF8, 8'h00, 8'h07, 8'hE0};
    send_q();
    wait_idle();
    checks++;
    if (wr_total - w0 != 2) begin
      errors++;
      $display("FAIL b2b_count: writes=%0d, expected 2", wr_total - w0);
    end
    checks++;
    if (wlog[w0[7:0]] !== 17'h1F800 || wlog[8'(w0 + 1)] !== 17'h107E0) begin
      errors++;
      $display("FAIL b2b_words: %h %h, expected 1f800 107e0", wlog[w0[7:0]], wlog[8'(w0 + 1)]);
    end
    checks++;
    if (cs_low - c0 != 10 || cs_rise - r0 != 1) begin
      errors++;
      $display("FAIL b2b_cs: low=%0d rises=%0d, expected 10 1", cs_low - c0, cs_rise - r0);
    end
    checks++;
    if ({lt24_rs, lt24_data} !== 17'h107E0) begin
      errors++;
      $display("FAIL b2b_hold: rs/data=%h, expected 107e0", {lt24_rs, lt24_data});
    end
  endtask

  task automatic test_hdr_err();
    int w0 = wr_total;
    tx_q = '{8'hC5};
    send_q();
    checks++;
    if ({hdr_err, busy} !== 2'b10) begin
      errors++;
      $display("FAIL hdr_set: hdr_err=%b busy=%b, expected 1 0", hdr_err, busy);
    end
    tx_q = '{8'h80, 8'h29};
    send_q();
    wait_idle();
    checks++;
    if (wr_total - w0 != 1 || wlog[w0[7:0]] !== 17'h00029) begin
      errors++;
      $display("FAIL hdr_recover: count=%0d word=%h, expected 1 00029", wr_total - w0, wlog[w0[7:0]]);
    end
    // Clear and a fresh bad header in the same cycle: the set must win.
    @(negedge clk);
    data_in        = 8'h00;
    data_in_enable = 1'b1;
    clr_status     = 1'b1;
    @(negedge clk);
    data_in_enable = 1'b0;
    clr_status     = 1'b0;
    checks++;
    if (hdr_err !== 1'b1) begin
      errors++;
      $display("FAIL hdr_set_wins: hdr_err=%b, expected 1", hdr_err);
    end
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    checks++;
    if ({hdr_err, overflow} !== 2'b00) begin
      errors++;
      $display("FAIL hdr_clear: hdr_err=%b overflow=%b, expected 0 0", hdr_err, overflow);
    end
  endtask

  // Eight words at one byte per cycle. Word 1 is popped straight away and the
  // engine pops again every 5 cycles, so words 1-7 fit and only word 8 meets
  // a full FIFO with no pop that cycle.
  task automatic test_overflow();
    int          w0 = wr_total;
    logic [16:0] exp_word;
    tx_q = '{8'h47};
    for (int i = 1; i <= 8; i++) begin
      tx_q.push_back(8'(8'hA0 + i));
      tx_q.push_back(8'(8'h50 + i));
    end
    send_q();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: overflow=%b, expected 1", overflow);
    end
    wait_idle();
    checks++;
    if (wr_total - w0 != 7) begin
      errors++;
      $display("FAIL ovf_count: writes=%0d, expected 7", wr_total - w0);
    end
    for (int i = 1; i <= 7; i++) begin
      exp_word = {1'b1, 8'(8'hA0 + i), 8'(8'h50 + i)};
      checks++;
      if (wlog[8'(w0 + i - 1)] !== exp_word) begin
        errors++;
        $display("FAIL ovf_word%0d: got %h, expected %h", i, wlog[8'(w0 + i - 1)], exp_word);
      end
    end
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: overflow=%b, expected 0", overflow);
    end
  endtask

  task automatic test_sync_clear();
    int w0 = wr_total;
    tx_q = '{8'h40, 8'h12};
    send_q();
    @(negedge clk);
    data_in        = 8'h34;
    data_in_enable = 1'b1;
    sync_clear     = 1'b1;
    @(negedge clk);
    data_in_enable = 1'b0;
    sync_clear     = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_total != w0) begin
      errors++;
      $display("FAIL sync_drop: busy=%b writes=%0d, expected 0 0", busy, wr_total - w0);
    end
    tx_q = '{8'h80, 8'h11};
    send_q();
    wait_idle();
    checks++;
    if (wr_total - w0 != 1 || wlog[w0[7:0]] !== 17'h00011) begin
      errors++;
      $display("FAIL sync_cmd: count=%0d word=%h, expected 1 00011", wr_total - w0, wlog[w0[7:0]]);
    end
  endtask

  task automatic test_reset_mid_write();
    int w0;
    int n = 0;
    tx_q = '{8'h80, 8'h55};
    send_q();
    while (lt24_wr_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (lt24_wr_n !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_reach: wr_n=%b after %0d cycles, expected 0", lt24_wr_n, n);
    end
    w0 = wr_total;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({lt24_cs_n, lt24_wr_n, busy, lt24_rs, lt24_data} !== {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL rst_mid_async: cs_n=%b wr_n=%b busy=%b rs=%b data=%h, expected 1 1 0 0 0000",
               lt24_cs_n, lt24_wr_n, busy, lt24_rs, lt24_data);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || lt24_cs_n !== 1'b1 || wr_total != w0) begin
      errors++;
      $display("FAIL rst_mid_after: busy=%b cs_n=%b writes=%0d, expected 0 1 0",
               busy, lt24_cs_n, wr_total - w0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_command();
    test_back_to_back();
    test_hdr_err();
    test_overflow();
    test_sync_clear();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
